// File: rtl/correlation_pkg.sv
// correlation_pkg: tap weights, widths and FSM states shared by the correlator and its inverse.
package correlation_pkg;
  localparam int TAP_FAR    = 2;
  localparam int TAP_NEAR   = 3;
  localparam int TAP_LEAD   = 4;
  localparam int LEAD_SHIFT = 2;
  localparam int SAMP_W     = 8;
  localparam int ACC_W      = 16;
  localparam int RES_W      = 19;
  localparam int CNT_W      = 16;
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_e;
endpackage

// File: rtl/correlation_inverse_if.sv
// correlation_inverse_if: correlator-sample input stream and decoded-sample output bundle.
interface correlation_inverse_if #(parameter int CNT_W = correlation_pkg::CNT_W);
  logic [correlation_pkg::ACC_W-1:0]  y_in;
  logic                               y_valid;
  logic                               sof;
  logic [correlation_pkg::SAMP_W-1:0] x_out;
  logic                               x_valid;
  logic                               err_frac;
  logic                               err_range;
  logic [CNT_W-1:0]                   sample_cnt;
  logic                               busy;
  modport master (output y_in, y_valid, sof,
                  input  x_out, x_valid, err_frac, err_range, sample_cnt, busy);
  modport slave  (input  y_in, y_valid, sof,
                  output x_out, x_valid, err_frac, err_range, sample_cnt, busy);
endinterface

// File: rtl/corr_inv_residual.sv
// corr_inv_residual: strips the history taps from Y, divides by the leading tap and clamps to a sample.
module corr_inv_residual #(
  parameter int TAP_NEAR   = correlation_pkg::TAP_NEAR,
  parameter int TAP_FAR    = correlation_pkg::TAP_FAR,
  parameter int LEAD_SHIFT = correlation_pkg::LEAD_SHIFT
) (
  input  logic [correlation_pkg::ACC_W-1:0]  y_i,
  input  logic [correlation_pkg::SAMP_W-1:0] h1_i,
  input  logic [correlation_pkg::SAMP_W-1:0] h2_i,
  output logic [correlation_pkg::SAMP_W-1:0] x_o,
  output logic                               frac_o,
  output logic                               range_o
);
  import correlation_pkg::*;
  logic signed [RES_W-1:0] r, q;
  logic                    over;
  // 19 bits hold -1275..65535 exactly, so the modular subtraction is the true signed residual
  assign r       = RES_W'(y_i) - RES_W'(TAP_NEAR) * RES_W'(h1_i) - RES_W'(TAP_FAR) * RES_W'(h2_i);
  assign q       = r >>> LEAD_SHIFT;
  assign over    = |q[RES_W-1:SAMP_W];
  assign x_o     = r[RES_W-1] ? '0 : over ? '1 : q[SAMP_W-1:0];
  assign frac_o  = |r[LEAD_SHIFT-1:0];
  assign range_o = r[RES_W-1] | over;
endmodule

// File: rtl/correlation_inverse.sv
// correlation_inverse: recovers x[k] from the 3-tap correlator stream, with frame control and sticky error flags.
module correlation_inverse #(
  parameter int TAP_NEAR   = correlation_pkg::TAP_NEAR,
  parameter int TAP_FAR    = correlation_pkg::TAP_FAR,
  parameter int LEAD_SHIFT = correlation_pkg::LEAD_SHIFT,
  parameter int CNT_W      = correlation_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  correlation_inverse_if.slave  bus
);
  import correlation_pkg::*;
  state_e            state_q;
  logic [SAMP_W-1:0] h1_q, h2_q, x_q, h1e, h2e, x_d;
  logic              xv_q, ef_q, er_q, ef_d, er_d, frac, range_e, accept;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  assign accept = bus.y_valid & (bus.sof | (state_q != IDLE));
  assign h1e    = bus.sof ? '0 : h1_q;
  assign h2e    = bus.sof ? '0 : h2_q;
  corr_inv_residual #(.TAP_NEAR(TAP_NEAR), .TAP_FAR(TAP_FAR), .LEAD_SHIFT(LEAD_SHIFT)) u_res (
    .y_i(bus.y_in), .h1_i(h1e), .h2_i(h2e), .x_o(x_d), .frac_o(frac), .range_o(range_e)
  );
  // a new frame drops the old sticky state in the same cycle it decodes its first sample
  always_comb begin
    ef_d  = frac | (ef_q & ~bus.sof);
    er_d  = range_e | (er_q & ~bus.sof);
    cnt_d = bus.sof ? CNT_W'(1) : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h1_q    <= '0;
      h2_q    <= '0;
      x_q     <= '0;
      xv_q    <= 1'b0;
      ef_q    <= 1'b0;
      er_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      xv_q <= accept;
      if (accept) begin
        x_q     <= x_d;
        h1_q    <= x_d;
        h2_q    <= h1e;
        ef_q    <= ef_d;
        er_q    <= er_d;
        cnt_q   <= cnt_d;
        state_q <= (ef_d | er_d) ? ERR : RUN;
      end
    end
  end
  assign bus.x_out      = x_q;
  assign bus.x_valid    = xv_q;
  assign bus.err_frac   = ef_q;
  assign bus.err_range  = er_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_correlation_inverse.sv
// tb_correlation_inverse: directed vector table plus hand sequences for stall, reset and count saturation.
module tb_correlation_inverse;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  correlation_inverse_if bus ();
  correlation_inverse dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        sof;
    logic [15:0] y;
    logic [7:0]  x;
    logic        ef;
    logic        er;
    logic [15:0] cnt;
  } vec_t;
  vec_t vt[13];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic check_out(input string n, input logic [7:0] x, input logic xv, input logic ef,
                           input logic er, input logic [15:0] cnt, input logic bz);
    chk({n, ".x_out"}, 32'(bus.x_out), 32'(x));
    chk({n, ".x_valid"}, 32'(bus.x_valid), 32'(xv));
    chk({n, ".err_frac"}, 32'(bus.err_frac), 32'(ef));
    chk({n, ".err_range"}, 32'(bus.err_range), 32'(er));
    chk({n, ".sample_cnt"}, 32'(bus.sample_cnt), 32'(cnt));
    chk({n, ".busy"}, 32'(bus.busy), 32'(bz));
  endtask
  task automatic step(input logic v, input logic s, input logic [15:0] y);
    @(negedge clk);
    bus.y_valid = v;
    bus.sof = s;
    bus.y_in = y;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vt[0]  = '{1'b1, 16'd4,     8'd1,   1'b0, 1'b0, 16'd1};
    vt[1]  = '{1'b0, 16'd11,    8'd2,   1'b0, 1'b0, 16'd2};
    vt[2]  = '{1'b0, 16'd20,    8'd3,   1'b0, 1'b0, 16'd3};
    vt[3]  = '{1'b1, 16'd1020,  8'd255, 1'b0, 1'b0, 16'd1};
    vt[4]  = '{1'b0, 16'd1785,  8'd255, 1'b0, 1'b0, 16'd2};
    vt[5]  = '{1'b0, 16'd2295,  8'd255, 1'b0, 1'b0, 16'd3};
    vt[6]  = '{1'b1, 16'd5,     8'd1,   1'b1, 1'b0, 16'd1};
    vt[7]  = '{1'b1, 16'd8,     8'd2,   1'b0, 1'b0, 16'd1};
    vt[8]  = '{1'b1, 16'd4,     8'd1,   1'b0, 1'b0, 16'd1};
    vt[9]  = '{1'b0, 16'd11,    8'd2,   1'b0, 1'b0, 16'd2};
    vt[10] = '{1'b1, 16'd12,    8'd3,   1'b0, 1'b0, 16'd1};
    vt[11] = '{1'b1, 16'd65535, 8'd255, 1'b1, 1'b1, 16'd1};
    vt[12] = '{1'b0, 16'd1020,  8'd63,  1'b1, 1'b1, 16'd2};
    bus.y_valid = 1'b0;
    bus.sof = 1'b0;
    bus.y_in = '0;
    #1;
    check_out("reset", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'd4);
    check_out("idle_no_sof", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      step(1'b1, vt[i].sof, vt[i].y);
      check_out($sformatf("vec%0d", i), vt[i].x, 1'b1, vt[i].ef, vt[i].er, vt[i].cnt, 1'b1);
    end
    step(1'b0, 1'b0, 16'd0);
    check_out("gap_after_vec", 8'd63, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1);
    step(1'b1, 1'b1, 16'd40);
    check_out("stall_first", 8'd10, 1'b1, 1'b0, 1'b0, 16'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i == 1, 16'd999);
      check_out($sformatf("stall%0d", i), 8'd10, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
    end
    step(1'b1, 1'b0, 16'd0);
    check_out("range_neg", 8'd0, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1);
    step(1'b1, 1'b1, 16'd4);
    step(1'b1, 1'b0, 16'd11);
    check_out("pre_reset", 8'd2, 1'b1, 1'b0, 1'b0, 16'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_out("async_reset", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'd4);
    check_out("post_reset_idle", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b1, 1'b1, 16'd4);
    check_out("post_reset_sof", 8'd1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b1);
    step(1'b1, 1'b1, 16'd0);
    for (int i = 0; i < 65534; i++) step(1'b1, 1'b0, 16'd0);
    check_out("cnt_max", 8'd0, 1'b1, 1'b0, 1'b0, 16'd65535, 1'b1);
    step(1'b1, 1'b0, 16'd0);
    check_out("cnt_sat", 8'd0, 1'b1, 1'b0, 1'b0, 16'd65535, 1'b1);
    step(1'b0, 1'b0, 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
